// File: rtl/panel_programmer.sv
// Front-panel memory loader: switches and debounced buttons enter an address and then
// a sequence of data words, which are written to RAM through a valid/ready port.
module panel_programmer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] i_switches,
    input  logic                  i_btn_store,
    input  logic                  i_btn_back,
    output logic                  o_wr_valid,
    input  logic                  i_wr_ready,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_prog,
    output logic [DATA_WIDTH-1:0] o_display,
    output logic [1:0]            o_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    store_prev_q, back_prev_q;
    logic                    store_edge, back_edge;

    assign store_edge = i_btn_store & ~store_prev_q;
    assign back_edge  = i_btn_back  & ~back_prev_q;

    // Next-state logic; dropping i_enable leaves every state except an in-flight write.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            ST_RUN: begin
                if (i_enable) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (!i_enable) begin
                    state_d = ST_RUN;
                end else if (store_edge) begin
                    addr_d  = i_switches[ADDR_WIDTH-1:0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!i_enable) begin
                    state_d = ST_RUN;
                end else if (store_edge) begin
                    data_d  = i_switches;
                    state_d = ST_WRITE;
                end else if (back_edge) begin
                    state_d = ST_ADDR;
                end
            end
            ST_WRITE: begin
                if (i_wr_ready) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = i_enable ? ST_DATA : ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_RUN;
            addr_q       <= '0;
            data_q       <= '0;
            store_prev_q <= 1'b0;
            back_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            store_prev_q <= i_btn_store;
            back_prev_q  <= i_btn_back;
        end
    end

    // Status outputs decode the state register only, so they cannot glitch.
    assign o_wr_valid = (state_q == ST_WRITE);
    assign o_prog     = (state_q != ST_RUN);
    assign o_state    = state_q;
    assign o_wr_addr  = addr_q;
    assign o_wr_data  = data_q;

    // The display follows the switches live while the operator is entering values.
    always_comb begin
        o_display = '0;
        unique case (state_q)
            ST_RUN:   o_display = '0;
            ST_ADDR:  o_display = DATA_WIDTH'(i_switches[ADDR_WIDTH-1:0]);
            ST_DATA:  o_display = i_switches;
            ST_WRITE: o_display = data_q;
            default:  o_display = '0;
        endcase
    end

endmodule

// File: tb/tb_panel_programmer.sv
// Bench for panel_programmer: directed vector table, hand-written corner sequences and
// randomized stimulus checked against a behavioural model of the front panel.
module tb_panel_programmer;

    logic       i_clk;
    logic       i_reset_n;
    logic       i_enable;
    logic [7:0] i_switches;
    logic       i_btn_store;
    logic       i_btn_back;
    logic       o_wr_valid;
    logic       i_wr_ready;
    logic [3:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic       o_prog;
    logic [7:0] o_display;
    logic [1:0] o_state;

    panel_programmer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_enable    (i_enable),
        .i_switches  (i_switches),
        .i_btn_store (i_btn_store),
        .i_btn_back  (i_btn_back),
        .o_wr_valid  (o_wr_valid),
        .i_wr_ready  (i_wr_ready),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_prog      (o_prog),
        .o_display   (o_display),
        .o_state     (o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: operator mode plus the panel's remembered address and data.
    localparam int RUN = 0, ADDR = 1, DATA = 2, WRITE = 3;
    int m_mode, m_addr, m_data, m_sprev, m_bprev;
    int m_writes;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = RUN; m_addr = 0; m_data = 0; m_sprev = 0; m_bprev = 0;
    endtask

    function automatic int model_display(input int sw);
        case (m_mode)
            ADDR:    return sw % 16;
            DATA:    return sw;
            WRITE:   return m_data;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input int en, input int sw, input int st, input int bk, input int rdy);
        bit s_edge, b_edge;
        s_edge = (st != 0) && (m_sprev == 0);
        b_edge = (bk != 0) && (m_bprev == 0);
        case (m_mode)
            RUN:  if (en != 0) m_mode = ADDR;
            ADDR: begin
                if (en == 0) m_mode = RUN;
                else if (s_edge) begin m_addr = sw % 16; m_mode = DATA; end
            end
            DATA: begin
                if (en == 0) m_mode = RUN;
                else if (s_edge) begin m_data = sw; m_mode = WRITE; end
                else if (b_edge) m_mode = ADDR;
            end
            default: begin
                if (rdy != 0) begin
                    m_writes++;
                    m_addr = (m_addr + 1) % 16;
                    m_mode = (en != 0) ? DATA : RUN;
                end
            end
        endcase
        m_sprev = st;
        m_bprev = bk;
    endtask

    task automatic model_check();
        chk("state",   int'(o_state),    m_mode);
        chk("valid",   int'(o_wr_valid), (m_mode == WRITE) ? 1 : 0);
        chk("prog",    int'(o_prog),     (m_mode != RUN) ? 1 : 0);
        chk("addr",    int'(o_wr_addr),  m_addr);
        chk("data",    int'(o_wr_data),  m_data);
        chk("display", int'(o_display),  model_display(int'(i_switches)));
    endtask

    // Called just after a falling edge: apply inputs, then compare before the next rise.
    task automatic drive_check(input logic en, input logic [7:0] sw, input logic st,
                               input logic bk, input logic rdy);
        i_enable = en; i_switches = sw; i_btn_store = st; i_btn_back = bk; i_wr_ready = rdy;
        #1;
        model_check();
    endtask

    task automatic clock_step();
        @(posedge i_clk);
        model_step(int'(i_enable), int'(i_switches), int'(i_btn_store),
                   int'(i_btn_back), int'(i_wr_ready));
        @(negedge i_clk);
    endtask

    task automatic step(input logic en, input logic [7:0] sw, input logic st,
                        input logic bk, input logic rdy);
        drive_check(en, sw, st, bk, rdy);
        clock_step();
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        model_reset();
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    typedef struct {
        logic       en;
        logic [7:0] sw;
        logic       st, bk, rdy;
        logic [1:0] e_state;
        logic       e_valid;
        logic [3:0] e_addr;
        logic [7:0] e_data;
        logic [7:0] e_disp;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        int wr_before;

        // Reset with buttons held high: everything reads zero.
        i_reset_n = 1'b0; i_enable = 1'b1; i_switches = 8'hFF;
        i_btn_store = 1'b1; i_btn_back = 1'b1; i_wr_ready = 1'b1;
        m_writes = 0;
        model_reset();
        @(negedge i_clk); @(negedge i_clk);
        chk("rst_state",   int'(o_state), 0);
        chk("rst_valid",   int'(o_wr_valid), 0);
        chk("rst_prog",    int'(o_prog), 0);
        chk("rst_addr",    int'(o_wr_addr), 0);
        chk("rst_data",    int'(o_wr_data), 0);
        chk("rst_display", int'(o_display), 0);
        i_reset_n = 1'b1;
        // Store held through release: no edge reaches ADDR, so no write ever happens.
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
            chk("held_store_state", int'(o_state), 1);
            chk("held_store_valid", int'(o_wr_valid), 0);
        end
        do_reset();

        // Directed vectors: basic load, wrap, simultaneous buttons, enable drop in DATA.
        tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'h0, 8'h00, 8'h05};
        tbl[2]  = '{1'b1, 8'hA7, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'h5, 8'h00, 8'hA7};
        tbl[3]  = '{1'b1, 8'hA7, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 4'h5, 8'h00, 8'hA7};
        tbl[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'h5, 8'hA7, 8'hA7};
        tbl[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 4'h6, 8'hA7, 8'h11};
        tbl[6]  = '{1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 4'h6, 8'hA7, 8'h0F};
        tbl[7]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'h6, 8'hA7, 8'h0F};
        tbl[8]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'hF, 8'hA7, 8'h3C};
        tbl[9]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 4'hF, 8'hA7, 8'h3C};
        tbl[10] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'hF, 8'h3C, 8'h3C};
        tbl[11] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'h0, 8'h3C, 8'h55};
        tbl[12] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 4'h0, 8'h3C, 8'h66};
        tbl[13] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'h0, 8'h66, 8'h66};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'h1, 8'h66, 8'h00};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h1, 8'h66, 8'h00};
        for (int i = 0; i < 16; i++) begin
            drive_check(tbl[i].en, tbl[i].sw, tbl[i].st, tbl[i].bk, tbl[i].rdy);
            chk($sformatf("vec%0d_state", i), int'(o_state),    int'(tbl[i].e_state));
            chk($sformatf("vec%0d_valid", i), int'(o_wr_valid), int'(tbl[i].e_valid));
            chk($sformatf("vec%0d_prog", i),  int'(o_prog),     (tbl[i].e_state != 2'd0) ? 1 : 0);
            chk($sformatf("vec%0d_addr", i),  int'(o_wr_addr),  int'(tbl[i].e_addr));
            chk($sformatf("vec%0d_data", i),  int'(o_wr_data),  int'(tbl[i].e_data));
            chk($sformatf("vec%0d_disp", i),  int'(o_display),  int'(tbl[i].e_disp));
            clock_step();
        end

        // Backpressure: valid held six cycles, payload frozen, extra stores ignored.
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h09, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        vcnt = 0;
        wr_before = m_writes;
        for (int k = 0; k < 5; k++) begin
            drive_check(1'b1, 8'($urandom), 1'(k % 2), 1'((k + 1) % 2), 1'b0);
            if (o_wr_valid) vcnt++;
            chk("bp_addr", int'(o_wr_addr), 9);
            chk("bp_data", int'(o_wr_data), 8'hC3);
            clock_step();
        end
        drive_check(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        if (o_wr_valid) vcnt++;
        clock_step();
        chk("bp_valid_cycles", vcnt, 6);
        chk("bp_single_accept", m_writes - wr_before, 1);
        drive_check(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("bp_after_state", int'(o_state), 2);
        chk("bp_after_addr", int'(o_wr_addr), 4'hA);
        clock_step();

        // Enable dropped mid-write: the write still completes, then RUN.
        step(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive_check(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("endrop_still_write", int'(o_state), 3);
        clock_step();
        drive_check(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("endrop_run", int'(o_state), 0);
        chk("endrop_prog", int'(o_prog), 0);
        chk("endrop_addr", int'(o_wr_addr), 4'hB);
        clock_step();

        // Back alone in DATA returns to ADDR with the address kept.
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        drive_check(1'b1, 8'hE2, 1'b0, 1'b1, 1'b0);
        chk("back_state", int'(o_state), 1);
        chk("back_display", int'(o_display), 8'h02);
        chk("back_addr", int'(o_wr_addr), 4'h3);
        clock_step();

        // Asynchronous reset in the middle of a write drops valid at once.
        step(1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        i_wr_ready = 1'b0;
        #1;
        chk("midrst_pre_valid", int'(o_wr_valid), 1);
        i_reset_n = 1'b0;
        #1;
        chk("midrst_valid", int'(o_wr_valid), 0);
        chk("midrst_state", int'(o_state), 0);
        chk("midrst_addr", int'(o_wr_addr), 0);
        model_reset();
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Randomized operation against the model.
        for (int c = 0; c < 600; c++) begin
            step(1'($urandom_range(0, 11) != 0), 8'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
